// File: rtl/popcount_accum.sv
// Popcount engine: counts set bits per word (mode 0) or accumulates them over a
// frame with saturation (mode 1), with valid/ready handshakes on both sides.
module popcount_accum #(
  parameter int WIDTH = 10,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_ge,
  output logic             out_sat
);

  if (WIDTH < 1 || WIDTH > 64 || ACC_W < $clog2(WIDTH + 1)) begin : g_bad_params
    $error("popcount_accum: WIDTH must be 1..64 and ACC_W >= clog2(WIDTH+1)");
  end

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc;
  logic             sat_q;
  logic             mode_q;
  logic             accept;
  logic             first;
  logic             frame_mode;
  logic             done;
  logic [ACC_W-1:0] pc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             sat_next;

  assign accept = in_valid && in_ready;

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + ACC_W'(in_data[i]);
    end
  end

  // Any word arriving outside ACC opens a new frame, so mode is only taken then.
  always_comb begin
    first      = (state != ACC);
    frame_mode = first ? mode : mode_q;
    acc_base   = first ? '0 : acc;
    sum        = {1'b0, acc_base} + {1'b0, pc};
    acc_next   = pc;
    sat_next   = 1'b0;
    if (frame_mode) begin
      acc_next = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
      sat_next = sum[ACC_W] | (~first & sat_q);
    end
    done = ~frame_mode | in_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = done ? OUT : ACC;
    end else if (state == OUT && out_ready) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    in_ready  = (state != OUT) || out_ready;
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sat_q     <= 1'b0;
      mode_q    <= 1'b0;
      out_count <= '0;
      out_ge    <= 1'b0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      if (first) begin
        mode_q <= mode;
      end
      acc   <= acc_next;
      sat_q <= sat_next;
      if (done) begin
        out_count <= acc_next;
        out_ge    <= (acc_next >= thresh);
        out_sat   <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Self-checking bench for popcount_accum (WIDTH=10, ACC_W=8): directed vectors,
// a frame-level reference model compared every cycle, and literal spot checks.
module tb_popcount_accum;

  localparam int WIDTH = 10;
  localparam int ACC_W = 8;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             mode = 1'b0;
  logic [ACC_W-1:0] thresh = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_count;
  logic             out_ge;
  logic             out_sat;

  int checks = 0;
  int errors = 0;

  // Reference model state: the result being offered and the open frame, if any.
  int m_valid = 0;
  int m_count = 0;
  int m_ge    = 0;
  int m_sat   = 0;
  int m_open  = 0;
  int m_mode  = 0;
  int m_acc   = 0;
  int m_satf  = 0;

  popcount_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .mode     (mode),
    .thresh   (thresh),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .out_ge   (out_ge),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic l,
                               input logic md, input logic [ACC_W-1:0] th, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    mode      = md;
    thresh    = th;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin : model
    int pc, total, result, sat, done;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 0; m_count = 0; m_ge = 0; m_sat = 0;
        m_open = 0; m_acc = 0; m_satf = 0;
      end else if (in_valid && (m_valid == 0 || out_ready)) begin
        pc = $countones(in_data);
        if (m_open == 0) begin
          m_mode = int'(mode);
          m_acc  = 0;
          m_satf = 0;
        end
        if (m_mode == 0) begin
          result = pc; sat = 0; done = 1;
        end else begin
          total = m_acc + pc;
          if (total > MAXV) begin
            total  = MAXV;
            m_satf = 1;
          end
          m_acc = total; result = total; sat = m_satf; done = int'(in_last);
        end
        if (done != 0) begin
          m_valid = 1; m_count = result; m_ge = (result >= int'(thresh)) ? 1 : 0;
          m_sat = sat; m_open = 0;
        end else begin
          m_valid = 0; m_open = 1;
        end
      end else if (m_valid != 0 && out_ready) begin
        m_valid = 0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      checkOutput("in_ready", 64'(in_ready), 64'((m_valid == 0) || out_ready));
      checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid != 0) begin
        checkOutput("out_count", 64'(out_count), 64'(m_count));
        checkOutput("out_ge", 64'(out_ge), 64'(m_ge));
        checkOutput("out_sat", 64'(out_sat), 64'(m_sat));
      end
    end
  end

  logic [WIDTH-1:0] vec_data   [4] = '{10'h000, 10'h3FF, 10'h201, 10'h155};
  logic [ACC_W-1:0] vec_thresh [4] = '{8'd0, 8'd11, 8'd2, 8'd6};
  int               vec_count  [4] = '{0, 10, 2, 5};
  int               vec_ge     [4] = '{1, 0, 1, 0};

  initial begin : stimulus
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_count", 64'(out_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // All-ones word in mode 0, result held with no consumer
    applyStimulus(1, 10'h3FF, 0, 0, 8'd10, 0);
    checkOutput("m0_valid", 64'(out_valid), 64'd1);
    checkOutput("m0_count", 64'(out_count), 64'd10);
    checkOutput("m0_ge", 64'(out_ge), 64'd1);
    checkOutput("m0_sat", 64'(out_sat), 64'd0);
    applyStimulus(0, 10'h000, 0, 0, 8'd10, 1);

    // Three-word frame; mode flips mid-frame must not matter
    applyStimulus(1, 10'h3FF, 0, 1, 8'd16, 1);
    checkOutput("frame_mid_valid", 64'(out_valid), 64'd0);
    applyStimulus(1, 10'h155, 0, 0, 8'd16, 1);
    checkOutput("frame_mid_valid2", 64'(out_valid), 64'd0);
    applyStimulus(1, 10'h000, 1, 0, 8'd16, 0);
    checkOutput("frame_valid", 64'(out_valid), 64'd1);
    checkOutput("frame_count", 64'(out_count), 64'd15);
    checkOutput("frame_ge", 64'(out_ge), 64'd0);

    // Backpressure: word waits while result is held
    in_valid = 1'b1; in_data = 10'h001; in_last = 1'b0; mode = 1'b0; out_ready = 1'b0;
    #1;
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_hold_count", 64'(out_count), 64'd15);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_new_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_new_count", 64'(out_count), 64'd1);
    applyStimulus(0, 10'h000, 0, 0, 8'd0, 1);

    // Saturating frame: 26 x 10 exceeds 255 on the last word
    for (int i = 0; i < 26; i++) begin
      applyStimulus(1, 10'h3FF, (i == 25), 1, 8'd0, 1);
      if (i == 24) checkOutput("sat_pending_valid", 64'(out_valid), 64'd0);
    end
    checkOutput("sat_count", 64'(out_count), 64'd255);
    checkOutput("sat_flag", 64'(out_sat), 64'd1);
    applyStimulus(1, 10'h001, 1, 1, 8'd0, 1);
    checkOutput("sat_next_count", 64'(out_count), 64'd1);
    checkOutput("sat_next_flag", 64'(out_sat), 64'd0);
    applyStimulus(0, 10'h000, 0, 0, 8'd0, 1);

    // Reset in the middle of an open frame
    applyStimulus(1, 10'h0FF, 0, 1, 8'd0, 1);
    applyStimulus(1, 10'h0FF, 0, 1, 8'd0, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_count", 64'(out_count), 64'd0);
    checkOutput("midrst_ge", 64'(out_ge), 64'd0);
    checkOutput("midrst_sat", 64'(out_sat), 64'd0);
    checkOutput("midrst_ready", 64'(in_ready), 64'd1);
    #1 rst_n = 1'b1;
    applyStimulus(1, 10'h003, 1, 1, 8'd0, 1);
    checkOutput("postrst_count", 64'(out_count), 64'd2);

    // Back-to-back mode-0 words, threshold boundaries
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, vec_data[i], 0, 0, vec_thresh[i], 1);
      checkOutput("b2b_count", 64'(out_count), 64'(vec_count[i]));
      checkOutput("b2b_ge", 64'(out_ge), 64'(vec_ge[i]));
    end
    applyStimulus(0, 10'h000, 0, 0, 8'd0, 1);
    applyStimulus(0, 10'h000, 0, 0, 8'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
